// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings and the forwarding-select helper for the RV32I hazard controller
package riscv_pkg;

    // EX operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Hazard FSM state encoding
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;

    // Forwarding source for one EX operand. The memory stage holds the younger
    // result, so it wins over writeback. x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       regwrite_m,
        input logic [4:0] rd_w,
        input logic       regwrite_w
    );
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - combinational EX-stage forwarding selector for both ALU operands
module hazard_fwd_unit
    import riscv_pkg::*;
(
    input  logic [4:0] rs_a,
    input  logic [4:0] rs_b,
    input  logic [4:0] rd_m,
    input  logic       regwrite_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_w,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Same priority rule applied to each operand's source register
    always_comb begin
        fwd_a = fwd_sel(rs_a, rd_m, regwrite_m, rd_w, regwrite_w);
        fwd_b = fwd_sel(rs_b, rd_m, regwrite_m, rd_w, regwrite_w);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard/stall/flush/forward controller; HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1D,
    input  logic [4:0]        rs2D,
    input  logic [4:0]        rs1E,
    input  logic [4:0]        rs2E,
    input  logic [4:0]        rdE,
    input  logic              memreadE,
    input  logic              pcsrcE,
    input  logic [4:0]        rdM,
    input  logic [4:0]        rdW,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              dmem_reqM,
    input  logic              dmem_ackM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB,
    output logic              mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_mem,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    localparam int CNT_W = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    // Reject configurations the wait counter and perf counters cannot represent
    if (MAX_WAIT < 2) begin : g_bad_max_wait
        $error("hazard_ctrl: MAX_WAIT must be at least 2");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("hazard_ctrl: PERF_W must be at least 1");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             mem_busy;
    logic             load_use;
    logic             full_stall;
    logic             br_flush;
    logic             lu_stall;

    hazard_fwd_unit u_fwd (
        .rs_a       (rs1E),
        .rs_b       (rs2E),
        .rd_m       (rdM),
        .regwrite_m (regwriteM),
        .rd_w       (rdW),
        .regwrite_w (regwriteW),
        .fwd_a      (fwdA),
        .fwd_b      (fwdB)
    );

    assign mem_busy = dmem_reqM && !dmem_ackM;
    assign load_use = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    // Next-state and hazard classification; a squashed decode instruction cannot
    // cause a load-use stall, so the branch flush is checked first
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        full_stall   = 1'b0;
        br_flush     = 1'b0;
        lu_stall     = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    full_stall   = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end else if (pcsrcE) begin
                    br_flush = 1'b1;
                end else if (load_use) begin
                    lu_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ackM) begin
                    full_stall = 1'b1;
                    if (wait_cnt == LAST_WAIT) begin
                        state_nxt = ERR;
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
                end else begin
                    // Pipe releases this cycle; the held EX instruction is judged afresh
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    if (pcsrcE) begin
                        br_flush = 1'b1;
                    end else if (load_use) begin
                        lu_stall = 1'b1;
                    end
                end
            end
            ERR: begin
                full_stall = 1'b1;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Pipeline register controls derived from the classified hazard
    always_comb begin
        stallF  = full_stall || lu_stall;
        stallD  = full_stall || lu_stall;
        stallE  = full_stall;
        stallM  = full_stall;
        flushD  = br_flush;
        flushE  = br_flush || lu_stall;
        flushW  = full_stall;
        mem_err = (state == ERR);
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for load-use stalls, memory stalls and branch flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu    <= '0;
            perf_mem   <= '0;
            perf_flush <= '0;
        end else begin
            if (lu_stall && (perf_lu != '1))
                perf_lu <= perf_lu + PERF_W'(1);
            if (full_stall && (perf_mem != '1))
                perf_mem <= perf_mem + PERF_W'(1);
            if (br_flush && (perf_flush != '1))
                perf_flush <= perf_flush + PERF_W'(1);
        end
    end
`endif

endmodule
